hps_led_driver: RTL and testbench

- Consumes the 8-bit LED PIO export of the HPS system and drives the board LEDs.
- Provides four display modes: direct, blink, breathe (PWM triangle) and chase (rotate).
- All timing derives from the single fabric clock, the same clock that feeds the HPS system.
- PIO and mode updates are applied only on PWM frame boundaries, so LED output never glitches mid-frame.

---
 rtl/hps_led_driver.sv | 152 +++++++++++++++
 tb/tb_hps_led_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hps_led_driver.sv
`default_nettype none
// ============================================================================
// Module   : hps_led_driver
// Purpose  : Drives the board LEDs from the 8-bit HPS LED PIO export, in one
//            of four display modes: direct, blink, breathe (PWM triangle) and
//            chase (rotate). Pattern and mode are shadow-loaded only at the end
//            of each 256-cycle PWM frame, so the LEDs never change mid-frame.
// Ports    : clk_clk        in   fabric clock (same domain as the HPS PIO)
//            reset_reset_n  in   asynchronous active-low reset
//            led_pio[7:0]   in   LED pattern from the HPS PIO export
//            mode[1:0]      in   00 direct, 01 blink, 10 breathe, 11 chase
//            enable         in   1 = run, 0 = LEDs off and timers frozen
//            led_out[7:0]   out  registered LED drive, active high
//            tick           out  one-cycle pulse per timing tick
// Revision : 1.0 - initial release
// ============================================================================
module hps_led_driver #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] led_pio,
  input  logic [1:0] mode,
  input  logic       enable,
  output logic [7:0] led_out,
  output logic       tick
);

  localparam int unsigned c_PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned c_BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_TICKS - 1);

  localparam logic [1:0] c_MODE_DIRECT  = 2'b00;
  localparam logic [1:0] c_MODE_BLINK   = 2'b01;
  localparam logic [1:0] c_MODE_BREATHE = 2'b10;

  logic [7:0]           pwm_cnt_q,   pwm_cnt_d;
  logic [c_PRESC_W-1:0] presc_q,     presc_d;
  logic [c_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                 phase_q,     phase_d;
  logic [7:0]           duty_q,      duty_d;
  logic                 dir_down_q,  dir_down_d;
  logic [2:0]           rot_q,       rot_d;
  logic [7:0]           pat_q,       pat_d;
  logic [1:0]           mode_q,      mode_d;
  logic [7:0]           led_out_q,   led_out_d;

  logic        w_load;
  logic        w_mode_chg;
  logic        w_tick;
  logic [15:0] w_rot2;
  logic [7:0]  w_disp;

  always_comb begin
    w_load     = (pwm_cnt_q == 8'hFF);
    w_mode_chg = w_load && (mode != mode_q);
    w_tick     = enable && (presc_q == c_PRESC_MAX);

    pwm_cnt_d   = pwm_cnt_q + 8'd1;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    duty_d      = duty_q;
    dir_down_d  = dir_down_q;
    rot_d       = rot_q;
    pat_d       = pat_q;
    mode_d      = mode_q;

    // The prescaler only advances while enabled and is never cleared by a
    // mode change, so tick spacing stays regular across mode switches.
    if (enable) begin
      presc_d = (presc_q == c_PRESC_MAX) ? '0 : presc_q + c_PRESC_W'(1);
    end

    if (w_load) begin
      pat_d  = led_pio;
      mode_d = mode;
    end

    // A mode change takes priority over a coincident tick: the new mode
    // always starts from a clean state and that tick is dropped.
    if (w_mode_chg) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
      duty_d      = 8'd0;
      dir_down_d  = 1'b0;
      rot_d       = 3'd0;
    end else if (w_tick) begin
      if (blink_cnt_q == c_BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
        rot_d       = rot_q + 3'd1;
      end else begin
        blink_cnt_d = blink_cnt_q + c_BLINK_W'(1);
      end
      // Triangle: turn around on arriving at an end value, so duty never
      // wraps past 255 or below 0.
      if (!dir_down_q) begin
        if (duty_q != 8'hFF) duty_d = duty_q + 8'd1;
        if (duty_q >= 8'hFE) dir_down_d = 1'b1;
      end else begin
        if (duty_q != 8'h00) duty_d = duty_q - 8'd1;
        if (duty_q <= 8'h01) dir_down_d = 1'b0;
      end
    end
  end

  // Rotate-left by rot: the upper byte of the doubled pattern shifted left.
  always_comb begin
    w_rot2 = {pat_q, pat_q} << rot_q;
    case (mode_q)
      c_MODE_DIRECT:  w_disp = pat_q;
      c_MODE_BLINK:   w_disp = phase_q ? pat_q : 8'h00;
      c_MODE_BREATHE: w_disp = (pwm_cnt_q < duty_q) ? pat_q : 8'h00;
      default:        w_disp = w_rot2[15:8];
    endcase
    led_out_d = enable ? w_disp : 8'h00;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_cnt_q   <= 8'd0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      duty_q      <= 8'd0;
      dir_down_q  <= 1'b0;
      rot_q       <= 3'd0;
      pat_q       <= 8'd0;
      mode_q      <= 2'b00;
      led_out_q   <= 8'd0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      duty_q      <= duty_d;
      dir_down_q  <= dir_down_d;
      rot_q       <= rot_d;
      pat_q       <= pat_d;
      mode_q      <= mode_d;
      led_out_q   <= led_out_d;
    end
  end

  assign led_out = led_out_q;
  assign tick    = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_hps_led_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_led_driver
// Purpose  : Self-checking bench for hps_led_driver (TICK_DIV=4,
//            BLINK_TICKS=2). A directed vector table covers reset, frame-
//            boundary updates and blink with enable gating; hand-written
//            sequences cover chase stepping and reset mid-breathe; a random
//            phase is checked every cycle against a counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_led_driver;

  localparam int TD = 4;
  localparam int BT = 2;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] led_pio;
  logic [1:0] mode;
  logic       enable;
  logic [7:0] led_out;
  logic       tick;

  always #5 clk_clk = ~clk_clk;

  hps_led_driver #(.TICK_DIV(TD), .BLINK_TICKS(BT)) u_dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .led_pio       (led_pio),
    .mode          (mode),
    .enable        (enable),
    .led_out       (led_out),
    .tick          (tick)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: plain counts since reset / since the last mode change.
  int         m_cyc;   // clock edges since reset release (pwm = m_cyc % 256)
  int         m_ne;    // enabled edges since reset (prescaler = m_ne % TD)
  int         m_nt;    // ticks applied to the current mode
  logic [7:0] m_pat;
  logic [1:0] m_mode;

  task automatic model_reset();
    m_cyc = 0; m_ne = 0; m_nt = 0; m_pat = 8'h00; m_mode = 2'b00;
  endtask

  function automatic logic [7:0] model_disp();
    int seg, pwm, t, duty, r, p;
    seg  = m_nt / BT;
    pwm  = m_cyc % 256;
    t    = m_nt % 510;
    duty = (t <= 255) ? t : 510 - t;
    r    = seg % 8;
    p    = int'(m_pat);
    case (m_mode)
      2'd0:    return m_pat;
      2'd1:    return (seg % 2 == 1) ? m_pat : 8'h00;
      2'd2:    return (pwm < duty) ? m_pat : 8'h00;
      default: return 8'(((p << r) | (p >> (8 - r))) & 255);
    endcase
  endfunction

  task automatic model_step(input logic [7:0] p, input logic [1:0] m, input logic e);
    bit ld, clr, tk;
    ld  = (m_cyc % 256 == 255);
    clr = ld && (m != m_mode);
    tk  = e && (m_ne % TD == TD - 1);
    if (e) m_ne++;
    if (clr) m_nt = 0;
    else if (tk) m_nt++;
    if (ld) begin m_pat = p; m_mode = m; end
    m_cyc++;
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: inputs applied at the falling edge, tick sampled 1 ns later,
  // led_out sampled 1 ns after the rising edge. Caller sits at posedge+1.
  task automatic cycle(input logic [7:0] p, input logic [1:0] m, input logic e);
    logic [7:0] exp_led;
    logic       exp_tick;
    @(negedge clk_clk);
    led_pio = p; mode = m; enable = e;
    #1;
    exp_tick = e && (m_ne % TD == TD - 1);
    exp_led  = e ? model_disp() : 8'h00;
    chk8("tick", {7'd0, tick}, {7'd0, exp_tick});
    @(posedge clk_clk);
    #1;
    chk8("led_model", led_out, exp_led);
    model_step(p, m, e);
  endtask

  typedef struct {
    logic [7:0] pio;
    logic [1:0] md;
    logic       en;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [17];
  logic [7:0] prev, exp8, rp;
  logic [1:0] rm;
  logic       re;
  int         cnt;
  bit         got;

  initial begin
    tbl[0]  = '{8'hA5, 2'd0, 1'b1, 256, 8'h00};  // before first frame load
    tbl[1]  = '{8'hA5, 2'd0, 1'b1,   1, 8'hA5};  // cycle 257 after release
    tbl[2]  = '{8'h0F, 2'd0, 1'b1, 254, 8'hA5};  // change mid-frame: held
    tbl[3]  = '{8'h0F, 2'd0, 1'b1,   1, 8'hA5};  // load edge itself
    tbl[4]  = '{8'h0F, 2'd0, 1'b1,   1, 8'h0F};
    tbl[5]  = '{8'h0F, 2'd0, 1'b1,   9, 8'h0F};  // now at pwm_cnt == 10
    tbl[6]  = '{8'hF0, 2'd0, 1'b1, 246, 8'h0F};
    tbl[7]  = '{8'hF0, 2'd0, 1'b1,   1, 8'hF0};
    tbl[8]  = '{8'h3C, 2'd1, 1'b1, 255, 8'hF0};  // blink load (tick lost)
    tbl[9]  = '{8'h3C, 2'd1, 1'b1,   1, 8'h00};  // starts dark
    tbl[10] = '{8'h3C, 2'd1, 1'b1,   7, 8'h00};  // dark for 8 cycles
    tbl[11] = '{8'h3C, 2'd1, 1'b1,   1, 8'h3C};  // first on cycle
    tbl[12] = '{8'h3C, 2'd1, 1'b0,   1, 8'h00};  // disable: off next cycle
    tbl[13] = '{8'h3C, 2'd1, 1'b0,   5, 8'h00};
    tbl[14] = '{8'h3C, 2'd1, 1'b1,   1, 8'h3C};  // resume on-phase
    tbl[15] = '{8'h3C, 2'd1, 1'b1,   6, 8'h3C};  // 7 more on cycles
    tbl[16] = '{8'h3C, 2'd1, 1'b1,   1, 8'h00};

    reset_reset_n = 1'b0;
    led_pio = 8'hA5; mode = 2'b00; enable = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_clk);
    #1;
    chk8("reset_led", led_out, 8'h00);
    chk8("reset_tick", {7'd0, tick}, 8'h00);
    reset_reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].pio, tbl[i].md, tbl[i].en);
      chk8($sformatf("table_%0d", i), led_out, tbl[i].exp);
    end

    // Chase: wait for rot=0 display, then follow 11 single-bit rotations.
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      cycle(8'h01, 2'd3, 1'b1);
      if (led_out == 8'h01) got = 1;
    end
    chkint("chase_start_seen", int'(got), 1);
    prev = 8'h01;
    for (int s = 0; s < 11; s++) begin
      cnt = 0; got = 0;
      while (!got && cnt < 20) begin
        cycle(8'h01, 2'd3, 1'b1);
        cnt++;
        if (led_out !== prev) got = 1;
      end
      exp8 = {prev[6:0], prev[7]};
      chk8($sformatf("chase_step_%0d", s), led_out, exp8);
      if (s > 0) chkint($sformatf("chase_interval_%0d", s), cnt, 2 * TD * BT / 2 * 2 / 2);
      prev = exp8;
    end
    repeat (257) cycle(8'h01, 2'd0, 1'b1);
    chk8("chase_to_direct", led_out, 8'h01);

    // Breathe, then reset part-way up the ramp (duty around 100).
    repeat (260) cycle(8'hFF, 2'd2, 1'b1);
    repeat (400) cycle(8'hFF, 2'd2, 1'b1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk8("reset_mid_breathe", led_out, 8'h00);
    model_reset();
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    for (int k = 0; k < 256; k++) begin
      cycle(8'hFF, 2'd2, 1'b1);
      chk8("dark_until_first_load", led_out, 8'h00);
    end
    // Full triangle (510 ticks) so both turnarounds are exercised.
    repeat (2100) cycle(8'hFF, 2'd2, 1'b1);

    // Randomized phase against the model.
    rp = 8'h5A; rm = 2'd3; re = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) rp = 8'($urandom);
      if ($urandom_range(299) == 0) rm = 2'($urandom);
      if ($urandom_range(re ? 63 : 7) == 0) re = ~re;
      cycle(rp, rm, re);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
